// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the fetch PC, issues single-outstanding requests to instruction memory
// and buffers responses in a DEPTH-entry queue. Optional macro FETCH_BUBBLE_CNT_EN adds BubbleCnt.
module fetch_queue_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        RedirectF,
    input  logic [31:0] TargetF,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrF,
    output logic [31:0] PcF,
    output logic        ValidF
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [31:0] BubbleCnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_r;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [31:0]   instr_q_r [DEPTH];
    logic [31:0]   pc_q_r    [DEPTH];

    logic valid_s;
    logic issue_s;
    logic push_s;
    logic pop_s;

    // Issue/push/pop decisions; issue is gated by reset so no request leaks while held in reset.
    always_comb begin
        valid_s = 1'b0;
        issue_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (count_r != {CW{1'b0}}) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
        if (!reset && (state_r == IDLE) && (count_r < CW'(DEPTH)) && !RedirectF) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if ((state_r == WAIT) && ImemAck && !RedirectF) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (valid_s && !StallF && !RedirectF) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign ImemReq  = issue_s;
    assign ImemAddr = fetch_pc_r;
    assign ValidF   = valid_s;
    assign InstrF   = valid_s ? instr_q_r[head_r] : 32'h0000_0000;
    assign PcF      = valid_s ? pc_q_r[head_r]    : 32'h0000_0000;

    // Request FSM, fetch PC and queue storage; a redirect flushes and overrides everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
            count_r    <= {CW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_q_r[i] <= 32'h0000_0000;
                pc_q_r[i]    <= 32'h0000_0000;
            end
        end else if (RedirectF) begin
            count_r    <= {CW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            fetch_pc_r <= TargetF;
            case (state_r)
                IDLE:    state_r <= IDLE;
                WAIT:    state_r <= ImemAck ? IDLE : DROP;
                DROP:    state_r <= ImemAck ? IDLE : DROP;
                default: state_r <= IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        req_pc_r <= fetch_pc_r;
                        state_r  <= WAIT;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                WAIT: begin
                    if (ImemAck) begin
                        fetch_pc_r <= req_pc_r + 32'd4;
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= WAIT;
                    end
                end
                DROP: begin
                    if (ImemAck) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: state_r <= IDLE;
            endcase
            if (push_s) begin
                instr_q_r[tail_r] <= ImemRdata;
                pc_q_r[tail_r]    <= req_pc_r;
                tail_r            <= tail_r + PW'(1'b1);
            end else begin
                tail_r            <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1'b1);
            end else begin
                head_r <= head_r;
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

`ifdef FETCH_BUBBLE_CNT_EN
    // Saturating count of cycles where downstream is ready but the queue is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BubbleCnt <= 32'h0000_0000;
        end else if (!valid_s && !StallF && (BubbleCnt != 32'hFFFF_FFFF)) begin
            BubbleCnt <= BubbleCnt + 32'd1;
        end else begin
            BubbleCnt <= BubbleCnt;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a memory model answers requests, a monitor checks
// request addresses and popped entries against queues filled by the directed stimulus.
module tb_fetch_queue_unit;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        RedirectF;
    logic [31:0] TargetF;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;
    logic [31:0] InstrF;
    logic [31:0] PcF;
    logic        ValidF;
`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] BubbleCnt;
`endif

    int checks = 0;
    int errors = 0;
    int lat = 1;
    logic [31:0] dead_addr = 32'hFFFF_FFF0;

    logic [31:0] exp_addr [$];
    logic [63:0] exp_pop  [$];

    fetch_queue_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .RedirectF(RedirectF), .TargetF(TargetF),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemRdata(ImemRdata),
        .InstrF(InstrF), .PcF(PcF), .ValidF(ValidF)
`ifdef FETCH_BUBBLE_CNT_EN
        , .BubbleCnt(BubbleCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {8'h13, a[23:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic stall, input int l);
        reset = 1'b1;
        StallF = stall;
        RedirectF = 1'b0;
        lat = l;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic exp_entry(input logic [31:0] pc);
        exp_pop.push_back({instr_of(pc), pc});
    endtask

    // Release the stall for two cycles: pops base, base+4 and fetch resumes at base+8, base+C.
    task automatic drain2(input logic [31:0] base);
        exp_entry(base);
        exp_entry(base + 32'd4);
        exp_addr.push_back(base + 32'd8);
        exp_addr.push_back(base + 32'd12);
        StallF = 1'b0;
        cyc(2);
        StallF = 1'b1;
        cyc(12);
    endtask

    task automatic end_check();
        chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
        chk("pop_queue_drained", 32'(exp_pop.size()), 32'd0);
        exp_addr.delete();
        exp_pop.delete();
    endtask

    // Memory model: captures a request on the falling edge, acks `lat` cycles later.
    initial begin : mem_model
        logic        pend;
        int          cnt;
        logic [31:0] pdata;
        pend = 1'b0;
        cnt = 0;
        pdata = 32'h0;
        ImemAck = 1'b0;
        ImemRdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset && ImemReq) begin
                pend = 1'b1;
                cnt = lat;
                pdata = (ImemAddr == dead_addr) ? 32'h0000_DEAD : instr_of(ImemAddr);
            end
            @(posedge clk);
            #1;
            if (reset) begin
                pend = 1'b0;
                ImemAck = 1'b0;
            end else if (pend && cnt <= 1) begin
                ImemAck = 1'b1;
                ImemRdata = pdata;
                pend = 1'b0;
            end else begin
                ImemAck = 1'b0;
                if (pend) cnt--;
            end
        end
    end

    // Monitor: compares every request and every accepted head entry against the scoreboard.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ImemReq) begin
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_unexpected: got request addr %h expected none at %0t", ImemAddr, $time);
                    end else begin
                        chk("req_addr", ImemAddr, exp_addr.pop_front());
                    end
                end
                if (ValidF) begin
                    checks++;
                    if (InstrF == 32'h0000_DEAD) begin
                        errors++;
                        $display("FAIL dropped_data: got InstrF %h expected anything else at %0t", InstrF, $time);
                    end
                end
                if (ValidF && !StallF && !RedirectF) begin
                    if (exp_pop.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got PcF %h expected no pop at %0t", PcF, $time);
                    end else begin
                        e = exp_pop.pop_front();
                        chk("pop_instr", InstrF, e[63:32]);
                        chk("pop_pc", PcF, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b1;
        StallF = 1'b0;
        RedirectF = 1'b0;
        TargetF = 32'h0;
        #2;
        chk("rst_req", 32'(ImemReq), 32'd0);
        chk("rst_valid", 32'(ValidF), 32'd0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_pc", PcF, 32'h0);
        chk("rst_addr", ImemAddr, 32'h0);

        // Streaming fetch, 1-cycle memory.
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_entry(32'h0);
        exp_entry(32'h4);
        exp_entry(32'h8);
        reset_dut(1'b0, 1);
        #2 chk("valid_c0", 32'(ValidF), 32'd0);
        cyc(1);
        #2 chk("valid_c1", 32'(ValidF), 32'd0);
        cyc(6);
        StallF = 1'b1;
        cyc(8);
        end_check();

        // Stall from start: exactly two requests, then drain.
        exp_addr = '{32'h0, 32'h4};
        reset_dut(1'b1, 1);
        cyc(8);
        chk("full_no_req", 32'(ImemReq), 32'd0);
        drain2(32'h0);
        end_check();

        // Redirect while waiting; the late response is dropped.
        exp_addr = '{32'h0, 32'h4, 32'h100, 32'h104};
        reset_dut(1'b1, 1);
        cyc(2);
        lat = 3;
        dead_addr = 32'h4;
        cyc(1);
        #2 chk("pre_flush_valid", 32'(ValidF), 32'd1);
        RedirectF = 1'b1;
        TargetF = 32'h100;
        cyc(1);
        RedirectF = 1'b0;
        lat = 1;
        #2 chk("flush_valid", 32'(ValidF), 32'd0);
        cyc(1);
        #2 chk("drop_ack_no_req", 32'(ImemReq), 32'd0);
        cyc(1);
        #2 chk("post_drop_req", 32'(ImemReq), 32'd1);
        chk("post_drop_addr", ImemAddr, 32'h100);
        cyc(8);
        dead_addr = 32'hFFFF_FFF0;
        drain2(32'h100);
        end_check();

        // Redirect in the same cycle as the ack.
        exp_addr = '{32'h0, 32'h200, 32'h204};
        reset_dut(1'b1, 1);
        cyc(1);
        RedirectF = 1'b1;
        TargetF = 32'h200;
        cyc(1);
        RedirectF = 1'b0;
        #2 chk("same_cyc_valid", 32'(ValidF), 32'd0);
        chk("same_cyc_req", 32'(ImemReq), 32'd1);
        chk("same_cyc_addr", ImemAddr, 32'h200);
        cyc(8);
        drain2(32'h200);
        end_check();

        // Asynchronous reset mid-WAIT with an entry queued.
        exp_addr = '{32'h0, 32'h4};
        reset_dut(1'b1, 1);
        cyc(2);
        lat = 5;
        cyc(1);
        #2 chk("pre_rst_valid", 32'(ValidF), 32'd1);
        chk("pre_rst_pc", PcF, 32'h0);
        #1 reset = 1'b1;
        #1 chk("async_valid", 32'(ValidF), 32'd0);
        chk("async_instr", InstrF, 32'h0);
        chk("async_pc", PcF, 32'h0);
        chk("async_req", 32'(ImemReq), 32'd0);
        end_check();
        exp_addr = '{32'h0, 32'h4};
        reset_dut(1'b1, 1);
        cyc(8);
        end_check();

`ifdef FETCH_BUBBLE_CNT_EN
        // Starved-cycle counter with a slow memory.
        exp_addr = '{32'h0, 32'h4, 32'h8};
        exp_entry(32'h0);
        reset_dut(1'b0, 10);
        chk("bubble_rst", BubbleCnt, 32'd0);
        cyc(5);
        #2 chk("bubble_c5", BubbleCnt, 32'd5);
        cyc(6);
        #2 chk("bubble_valid", 32'(ValidF), 32'd1);
        chk("bubble_c11", BubbleCnt, 32'd11);
        cyc(1);
        StallF = 1'b1;
        #2 chk("bubble_hold", BubbleCnt, 32'd11);
        cyc(25);
        chk("bubble_stalled", BubbleCnt, 32'd11);
        end_check();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
